packetizer: RTL and testbench



---
 rtl/packetizer.sv | 118 +++++++++++
 tb/tb_packetizer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packetizer.sv
// Three-beat packet builder with an output FIFO and a valid/ready handshake on each side.
// Optional macro PACKETIZER_HDR_CHECK_EN enables the sticky header-mismatch flag.
module packetizer #(
  parameter int FILTER_WIDTH = 8,
  parameter int DEPTH        = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [FILTER_WIDTH-1:0]         in_data,
  input  logic [1:0]                      in_filter_row,
  input  logic                            in_ifmapb_filter,
  input  logic                            in_timestep,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [3*FILTER_WIDTH+3:0]       out_packet,
  output logic [$clog2(DEPTH+1)-1:0]      fifo_count,
  output logic                            hdr_err
);

  localparam int PW = 3*FILTER_WIDTH+4;
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    B0,
    B1,
    B2
  } beat_t;

  beat_t beat, beat_d;

  logic [FILTER_WIDTH-1:0] slot0, slot1;
  logic [1:0]              hdr_fr;
  logic                    hdr_ib;
  logic                    hdr_ts;
  logic [PW-1:0]           mem [DEPTH];
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic                    accept, push, pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Beat 2 only looks at registered occupancy, never at out_ready.
  assign in_ready   = (beat != B2) ||
                      (fifo_count < CW'(DEPTH));
  assign accept     = in_valid && in_ready;
  assign push       = accept && (beat == B2);
  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;
  assign out_packet = mem[rd_ptr];

  always_comb begin
    beat_d = beat;
    if (accept) begin
      unique case (beat)
        B0:      beat_d = B1;
        B1:      beat_d = B2;
        default: beat_d = B0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat <= B0;
    else        beat <= beat_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0      <= '0;
      slot1      <= '0;
      hdr_fr     <= '0;
      hdr_ib     <= 1'b0;
      hdr_ts     <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept && beat == B0) begin
        slot0  <= in_data;
        hdr_fr <= in_filter_row;
        hdr_ib <= in_ifmapb_filter;
        hdr_ts <= in_timestep;
      end
      if (accept && beat == B1) slot1 <= in_data;
      if (push) begin
        mem[wr_ptr] <= {in_data, slot1, slot0,
                        hdr_fr, hdr_ib, hdr_ts};
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

`ifdef PACKETIZER_HDR_CHECK_EN
  logic hdr_mis;

  assign hdr_mis = accept && (beat != B0) &&
                   ({in_filter_row, in_ifmapb_filter, in_timestep}
                    != {hdr_fr, hdr_ib, hdr_ts});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       hdr_err <= 1'b0;
    else if (hdr_mis) hdr_err <= 1'b1;
  end
`else
  assign hdr_err = 1'b0;
`endif

endmodule

// File: tb/tb_packetizer.sv
// Directed self-checking bench for packetizer (FILTER_WIDTH=8, DEPTH=4).
// Header-check expectations follow PACKETIZER_HDR_CHECK_EN.
module tb_packetizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_filter_row = '0;
  logic        in_ifmapb_filter = 1'b0;
  logic        in_timestep = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [27:0] out_packet;
  logic [2:0]  fifo_count;
  logic        hdr_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PACKETIZER_HDR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  packetizer #(.FILTER_WIDTH(8), .DEPTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_filter_row    (in_filter_row),
    .in_ifmapb_filter (in_ifmapb_filter),
    .in_timestep      (in_timestep),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_packet       (out_packet),
    .fifo_count       (fifo_count),
    .hdr_err          (hdr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_of(input int k, input int i);
    return 8'(16*k + i + 1);
  endfunction

  function automatic logic [27:0] mk(input int k);
    logic [1:0] fr;
    fr = 2'(k);
    return {byte_of(k, 2), byte_of(k, 1), byte_of(k, 0),
            fr, 1'(k), ~1'(k)};
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic [1:0] fr,
                           input logic ib, input logic ts);
    int n;
    in_valid = 1'b1;
    in_data = d;
    in_filter_row = fr;
    in_ifmapb_filter = ib;
    in_timestep = ts;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_beat_k(input int k, input int i);
    send_beat(byte_of(k, i), 2'(k), 1'(k), ~1'(k));
  endtask

  task automatic send_k(input int k);
    for (int i = 0; i < 3; i++) send_beat_k(k, i);
  endtask

  task automatic do_reset;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_packet !== 28'h0) begin n_fail++; $display("FAIL rst_out_packet: got %h want 0", out_packet); end
    n_checks++;
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    n_checks++;
    if (hdr_err !== 1'b0) begin n_fail++; $display("FAIL rst_hdr_err: got %b want 0", hdr_err); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send_beat(8'h11, 2'd2, 1'b1, 1'b1);
    send_beat(8'h22, 2'd2, 1'b1, 1'b1);
    send_beat(8'h33, 2'd2, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_checks++;
    if (out_packet !== 28'h332211B) begin n_fail++; $display("FAIL basic_packet: got %h want 332211b", out_packet); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_k(k);
    n_checks++;
    if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_full: got %0d want 4", fifo_count); end
    n_checks++;
    if (out_packet !== 28'h1312116) begin n_fail++; $display("FAIL bp_head1: got %h want 1312116", out_packet); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_b%0d: got %b want 1", i, in_ready); end
      send_beat_k(5, i);
    end
    in_valid = 1'b1;
    in_data = byte_of(5, 2);
    in_filter_row = 2'd1;
    in_ifmapb_filter = 1'b1;
    in_timestep = 1'b0;
    repeat (3) begin
      n_checks++;
      if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
        n_fail++;
        $display("FAIL bp_block: in_ready=%b count=%0d want 0/4", in_ready, fifo_count);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n_checks++;
    if (out_packet !== mk(1)) begin n_fail++; $display("FAIL bp_pop1: got %h want %h", out_packet, mk(1)); end
    @(posedge clk); #1;
    n_checks++;
    if (fifo_count !== 3'd3 || out_packet !== mk(2) || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pop2: count=%0d pkt=%h rdy=%b want 3/%h/1", fifo_count, out_packet, in_ready, mk(2));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      n_checks++;
      if (fifo_count !== 3'(6 - k) || out_packet !== mk(k)) begin
        n_fail++;
        $display("FAIL bp_pop%0d: count=%0d pkt=%h want %0d/%h", k, fifo_count, out_packet, 6 - k, mk(k));
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_empty: valid=%b count=%0d want 0/0", out_valid, fifo_count);
    end
  endtask

  task automatic test_wrap;
    logic [27:0] exp_q[$];
    int got;
    bit over;
    got = 0;
    over = 1'b0;
    fork
      begin
        for (int k = 20; k < 30; k++) begin
          exp_q.push_back(mk(k));
          send_k(k);
        end
      end
      begin
        for (int c = 0; c < 600 && got < 10; c++) begin
          logic r;
          @(negedge clk);
          if (fifo_count > 3'd4) over = 1'b1;
          r = 1'($urandom_range(0, 1));
          out_ready = r;
          if (r && out_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL wrap_extra: got %h want none", out_packet);
            end else begin
              if (out_packet !== exp_q[0]) begin
                n_fail++;
                $display("FAIL wrap_pkt%0d: got %h want %h", got, out_packet, exp_q[0]);
              end
              void'(exp_q.pop_front());
            end
            got++;
          end
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    n_checks++;
    if (got != 10 || over) begin
      n_fail++;
      $display("FAIL wrap_total: got=%0d overflow=%b want 10/0", got, over);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_simul;
    out_ready = 1'b0;
    send_k(6);
    send_beat_k(7, 0);
    send_beat_k(7, 1);
    out_ready = 1'b1;
    send_beat_k(7, 2);
    n_checks++;
    if (fifo_count !== 3'd1 || out_packet !== mk(7) || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL simul: count=%0d pkt=%h valid=%b want 1/%h/1", fifo_count, out_packet, out_valid, mk(7));
    end
    @(posedge clk); #1;
    n_checks++;
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL simul_drain: got %0d want 0", fifo_count); end
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b0;
    send_k(8);
    send_k(9);
    send_beat_k(10, 0);
    send_beat_k(10, 1);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_packet !== 28'h0 ||
        fifo_count !== 3'd0 || hdr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_outs: rdy=%b v=%b pkt=%h cnt=%0d err=%b want 1/0/0/0/0",
               in_ready, out_valid, out_packet, fifo_count, hdr_err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(8'h01, 2'd0, 1'b0, 1'b0);
    send_beat(8'h02, 2'd0, 1'b0, 1'b0);
    send_beat(8'h03, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (fifo_count !== 3'd1 || out_packet !== 28'h0302010) begin
      n_fail++;
      $display("FAIL mid_rst_clean: count=%0d pkt=%h want 1/0302010", fifo_count, out_packet);
    end
  endtask

  task automatic test_hdr_check;
    do_reset();
    out_ready = 1'b0;
    send_beat(8'hA1, 2'd1, 1'b0, 1'b1);
    n_checks++;
    if (hdr_err !== 1'b0) begin n_fail++; $display("FAIL hdr_b0: got %b want 0", hdr_err); end
    send_beat(8'hA2, 2'd1, 1'b0, 1'b0);
    n_checks++;
    if (hdr_err !== EXP_ERR) begin n_fail++; $display("FAIL hdr_set: got %b want %b", hdr_err, EXP_ERR); end
    send_beat(8'hA3, 2'd1, 1'b0, 1'b1);
    n_checks++;
    if (out_packet !== 28'hA3A2A15) begin n_fail++; $display("FAIL hdr_pkt: got %h want a3a2a15", out_packet); end
    send_k(11);
    n_checks++;
    if (hdr_err !== EXP_ERR || fifo_count !== 3'd2) begin
      n_fail++;
      $display("FAIL hdr_sticky: err=%b count=%0d want %b/2", hdr_err, fifo_count, EXP_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_simul();
    test_mid_reset();
    test_hdr_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
